psram_arbiter: RTL and testbench

PSRAM_ARBITER -- requirements
Module: psram_arbiter

---
 rtl/psram_arbiter_pkg.sv | 24 ++
 rtl/psram_arb_port.sv | 64 ++++++
 rtl/psram_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_psram_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_arbiter_pkg.sv
// Shared definitions for the PSRAM arbiter: FSM encoding, requester indices,
// timeout data pattern and the round-robin pick helper.
package psram_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } arb_state_e;

    localparam logic PortM0 = 1'b0;
    localparam logic PortM1 = 1'b1;

    localparam logic [31:0] TmoData = 32'hDEADBEEF;

    // With both ports pending, the port that was not served last wins.
    function automatic logic rr_pick(input logic pend0, input logic pend1, input logic last);
        if (pend0 && pend1) begin
            return ~last;
        end
        return pend0 ? PortM0 : PortM1;
    endfunction

endpackage

// File: rtl/psram_arb_port.sv
// Per-requester front end: captures a request, holds it until completion,
// keeps the last read data and produces the one-cycle ready pulse.
module psram_arb_port
    import psram_arbiter_pkg::*;
#(
    parameter int unsigned AW = 23,
    parameter int unsigned DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_a,
    input  logic [DW-1:0] i_d,
    input  logic          i_rd,
    input  logic          i_we,
    input  logic          i_cpl,
    input  logic [DW-1:0] i_cpl_data,
    output logic          o_pend,
    output logic          o_kind_we,
    output logic [AW-1:0] o_a,
    output logic [DW-1:0] o_d,
    output logic [DW-1:0] o_spo,
    output logic          o_ready
);

    logic          r_pend;
    logic          r_we;
    logic [AW-1:0] r_a;
    logic [DW-1:0] r_d;
    logic [DW-1:0] r_spo;
    logic          r_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend  <= 1'b0;
            r_we    <= 1'b0;
            r_a     <= '0;
            r_d     <= '0;
            r_spo   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= i_cpl;
            if (i_cpl) begin
                r_pend <= 1'b0;
                if (!r_we) begin
                    r_spo <= i_cpl_data;
                end
            end else if (!r_pend && (i_rd || i_we)) begin
                // Write wins when both strobes are high.
                r_pend <= 1'b1;
                r_we   <= i_we;
                r_a    <= i_a;
                r_d    <= i_d;
            end
        end
    end

    assign o_pend    = r_pend;
    assign o_kind_we = r_we;
    assign o_a       = r_a;
    assign o_d       = r_d;
    assign o_spo     = r_spo;
    assign o_ready   = r_ready;

endmodule

// File: rtl/psram_arbiter.sv
// Two-requester round-robin arbiter in front of a single PSRAM controller.
// Optional WAIT timeout with sticky error enabled by PSRAM_ARB_TIMEOUT_EN.
module psram_arbiter
    import psram_arbiter_pkg::*;
#(
    parameter int unsigned AW      = 23,
    parameter int unsigned DW      = 32,
    parameter int unsigned TMO_CYC = 1023
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_m0_a,
    input  logic [DW-1:0] i_m0_d,
    input  logic          i_m0_rd,
    input  logic          i_m0_we,
    output logic [DW-1:0] o_m0_spo,
    output logic          o_m0_ready,
    input  logic [AW-1:0] i_m1_a,
    input  logic [DW-1:0] i_m1_d,
    input  logic          i_m1_rd,
    input  logic          i_m1_we,
    output logic [DW-1:0] o_m1_spo,
    output logic          o_m1_ready,
    output logic [AW-1:0] o_s_a,
    output logic [DW-1:0] o_s_d,
    output logic          o_s_rd,
    output logic          o_s_we,
    input  logic [DW-1:0] i_s_spo,
    input  logic          i_s_ready,
    output logic          o_busy,
    output logic          o_err
);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    logic          r_gnt;
    logic          w_gnt_nxt;
    logic          r_last;
    logic          w_grant;
    logic          w_done;
    logic          w_tmo;
    logic [DW-1:0] w_cpl_data;

    logic [AW-1:0] r_s_a;
    logic [DW-1:0] r_s_d;
    logic          r_s_rd;
    logic          r_s_we;

    logic          w_m0_pend, w_m0_we, w_m0_cpl;
    logic          w_m1_pend, w_m1_we, w_m1_cpl;
    logic [AW-1:0] w_m0_a, w_m1_a, w_sel_a;
    logic [DW-1:0] w_m0_d, w_m1_d, w_sel_d;
    logic          w_sel_we;

    psram_arb_port #(
        .AW (AW),
        .DW (DW)
    ) u_port_m0 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_a        (i_m0_a),
        .i_d        (i_m0_d),
        .i_rd       (i_m0_rd),
        .i_we       (i_m0_we),
        .i_cpl      (w_m0_cpl),
        .i_cpl_data (w_cpl_data),
        .o_pend     (w_m0_pend),
        .o_kind_we  (w_m0_we),
        .o_a        (w_m0_a),
        .o_d        (w_m0_d),
        .o_spo      (o_m0_spo),
        .o_ready    (o_m0_ready)
    );

    psram_arb_port #(
        .AW (AW),
        .DW (DW)
    ) u_port_m1 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_a        (i_m1_a),
        .i_d        (i_m1_d),
        .i_rd       (i_m1_rd),
        .i_we       (i_m1_we),
        .i_cpl      (w_m1_cpl),
        .i_cpl_data (w_cpl_data),
        .o_pend     (w_m1_pend),
        .o_kind_we  (w_m1_we),
        .o_a        (w_m1_a),
        .o_d        (w_m1_d),
        .o_spo      (o_m1_spo),
        .o_ready    (o_m1_ready)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_grant     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_m0_pend || w_m1_pend) begin
                    w_grant     = 1'b1;
                    w_gnt_nxt   = rr_pick(w_m0_pend, w_m1_pend, r_last);
                    w_state_nxt = StIssue;
                end
            end
            StIssue: w_state_nxt = StWait;
            StWait: begin
                if (w_done) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Ready from the controller only counts while a transaction is outstanding.
    assign w_done   = (r_state == StWait) && (i_s_ready || w_tmo);
    assign w_m0_cpl = w_done && (r_gnt == PortM0);
    assign w_m1_cpl = w_done && (r_gnt == PortM1);

    assign w_sel_we = (w_gnt_nxt == PortM1) ? w_m1_we : w_m0_we;
    assign w_sel_a  = (w_gnt_nxt == PortM1) ? w_m1_a  : w_m0_a;
    assign w_sel_d  = (w_gnt_nxt == PortM1) ? w_m1_d  : w_m0_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gnt  <= PortM0;
            r_last <= PortM1;
            r_s_a  <= '0;
            r_s_d  <= '0;
            r_s_rd <= 1'b0;
            r_s_we <= 1'b0;
        end else begin
            r_gnt  <= w_gnt_nxt;
            r_s_rd <= w_grant && !w_sel_we;
            r_s_we <= w_grant && w_sel_we;
            if (w_grant) begin
                r_s_a <= w_sel_a;
                r_s_d <= w_sel_d;
            end
            if (w_done) begin
                r_last <= r_gnt;
            end
        end
    end

    assign o_s_a  = r_s_a;
    assign o_s_d  = r_s_d;
    assign o_s_rd = r_s_rd;
    assign o_s_we = r_s_we;
    assign o_busy = (r_state != StIdle);

`ifdef PSRAM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TMO_CYC + 1);

    logic [CntW-1:0] r_tmo_cnt;
    logic            r_err;

    // Counts completed WAIT cycles; fires on the TMO_CYC-th one without s_ready.
    assign w_tmo = (r_state == StWait) && !i_s_ready && (r_tmo_cnt == CntW'(TMO_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_tmo_cnt <= (r_state == StWait) ? r_tmo_cnt + 1'b1 : '0;
            if (w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_cpl_data = w_tmo ? DW'(TmoData) : i_s_spo;
    assign o_err      = r_err;
`else
    assign w_tmo      = 1'b0;
    assign w_cpl_data = i_s_spo;
    assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter: directed requests push expected controller
// commands and completions; a monitor pops and compares as the DUT emits them.
module tb_psram_arbiter;

    localparam int AW = 23;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0_a, m1_a, s_a;
    logic [DW-1:0] m0_d, m1_d, s_d, m0_spo, m1_spo, s_spo;
    logic          m0_rd, m0_we, m0_ready, m1_rd, m1_we, m1_ready;
    logic          s_rd, s_we, s_ready, busy, err;

    psram_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .TMO_CYC (16)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_m0_a     (m0_a),
        .i_m0_d     (m0_d),
        .i_m0_rd    (m0_rd),
        .i_m0_we    (m0_we),
        .o_m0_spo   (m0_spo),
        .o_m0_ready (m0_ready),
        .i_m1_a     (m1_a),
        .i_m1_d     (m1_d),
        .i_m1_rd    (m1_rd),
        .i_m1_we    (m1_we),
        .o_m1_spo   (m1_spo),
        .o_m1_ready (m1_ready),
        .o_s_a      (s_a),
        .o_s_d      (s_d),
        .o_s_rd     (s_rd),
        .o_s_we     (s_we),
        .i_s_spo    (s_spo),
        .i_s_ready  (s_ready),
        .o_busy     (busy),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            at;
    } cmd_t;

    typedef struct {
        logic [DW-1:0] spo;
        int            at;
    } cpl_t;

    cmd_t cmd_q[$];
    cpl_t cpl0_q[$];
    cpl_t cpl1_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Controller model: answers every command resp_delay cycles later.
    int            resp_cnt   = 0;
    int            resp_delay = 3;
    bit            resp_en    = 1'b1;
    bit            stray      = 1'b0;
    logic [DW-1:0] resp_data  = '0;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return (a == 23'h000100) ? 32'h12345678 : (32'hC0DE0000 | DW'(a));
    endfunction

    initial begin
        s_ready = 1'b0;
        s_spo   = '0;
        forever begin
            @(negedge clk);
            s_ready = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    s_ready = 1'b1;
                    s_spo   = resp_data;
                end
            end
            if (stray) begin
                s_ready = 1'b1;
                s_spo   = 32'hBAD0BAD0;
                stray   = 1'b0;
            end
            if ((s_rd || s_we) && resp_en) begin
                resp_cnt  = resp_delay;
                resp_data = mem_val(s_a);
            end
        end
    end

    // Monitor: every command and every ready pulse must match the head of its queue.
    initial begin
        forever begin
            @(negedge clk);
            if (s_rd || s_we) begin
                if (cmd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cmd: rd=%0b we=%0b a=0x%0h, none expected", s_rd,
                             s_we, s_a);
                end else begin
                    cmd_t e;
                    e = cmd_q.pop_front();
                    check("cmd_we", {63'd0, s_we}, {63'd0, e.we});
                    check("cmd_both", {63'd0, s_rd & s_we}, 64'd0);
                    check("cmd_a", 64'(s_a), 64'(e.a));
                    if (e.we) check("cmd_d", 64'(s_d), 64'(e.d));
                    check("cmd_cycle", 64'(cyc), 64'(e.at));
                end
            end
            if (m0_ready) begin
                if (cpl0_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_m0_ready: spo=0x%0h, none expected", m0_spo);
                end else begin
                    cpl_t e;
                    e = cpl0_q.pop_front();
                    check("m0_spo", 64'(m0_spo), 64'(e.spo));
                    check("m0_ready_cycle", 64'(cyc), 64'(e.at));
                end
            end
            if (m1_ready) begin
                if (cpl1_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_m1_ready: spo=0x%0h, none expected", m1_spo);
                end else begin
                    cpl_t e;
                    e = cpl1_q.pop_front();
                    check("m1_spo", 64'(m1_spo), 64'(e.spo));
                    check("m1_ready_cycle", 64'(cyc), 64'(e.at));
                end
            end
        end
    end

    // Called at a negedge; drives the request strobes for exactly one cycle.
    task automatic pulse(input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic r1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        m0_rd = r0;
        m0_we = w0;
        m0_a  = a0;
        m0_d  = d0;
        m1_rd = r1;
        m1_we = w1;
        m1_a  = a1;
        m1_d  = d1;
        @(negedge clk);
        m0_rd = 1'b0;
        m0_we = 1'b0;
        m1_rd = 1'b0;
        m1_we = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((cmd_q.size() != 0 || cpl0_q.size() != 0 || cpl1_q.size() != 0 || busy)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain: %0d cmd / %0d m0 / %0d m1 still outstanding, want 0",
                     cmd_q.size(), cpl0_q.size(), cpl1_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_rd"}, {63'd0, s_rd}, 64'd0);
        check({tag, "_s_we"}, {63'd0, s_we}, 64'd0);
        check({tag, "_m0_ready"}, {63'd0, m0_ready}, 64'd0);
        check({tag, "_m1_ready"}, {63'd0, m1_ready}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_err"}, {63'd0, err}, 64'd0);
        check({tag, "_s_a"}, 64'(s_a), 64'd0);
        check({tag, "_s_d"}, 64'(s_d), 64'd0);
        check({tag, "_m0_spo"}, 64'(m0_spo), 64'd0);
        check({tag, "_m1_spo"}, 64'(m1_spo), 64'd0);
    endtask

    initial begin
        int t;
        rst   = 1'b1;
        m0_a  = '0;
        m0_d  = '0;
        m0_rd = 1'b0;
        m0_we = 1'b0;
        m1_a  = '0;
        m1_d  = '0;
        m1_rd = 1'b0;
        m1_we = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Lone m0 read: s_rd two cycles after request, ready one after s_ready.
        t = cyc;
        cmd_q.push_back('{1'b0, 23'h000100, 32'h0, t + 2});
        cpl0_q.push_back('{32'h12345678, t + 6});
        pulse(1'b1, 1'b0, 23'h000100, 32'h0, 1'b0, 1'b0, 23'h0, 32'h0);
        drain(40);
        check("m0_spo_after_read", 64'(m0_spo), 64'h12345678);

        // Simultaneous pair after reset: m0 first, m1 after one IDLE cycle.
        do_reset();
        t = cyc;
        cmd_q.push_back('{1'b1, 23'h000200, 32'hAAAA5555, t + 2});
        cpl0_q.push_back('{32'h0, t + 6});
        cmd_q.push_back('{1'b0, 23'h000300, 32'h0, t + 7});
        cpl1_q.push_back('{32'hC0DE0300, t + 11});
        pulse(1'b0, 1'b1, 23'h000200, 32'hAAAA5555, 1'b1, 1'b0, 23'h000300, 32'h0);
        drain(60);

        // After a lone m0 transaction the next simultaneous pair favours m1.
        t = cyc;
        cmd_q.push_back('{1'b0, 23'h000400, 32'h0, t + 2});
        cpl0_q.push_back('{32'hC0DE0400, t + 6});
        pulse(1'b1, 1'b0, 23'h000400, 32'h0, 1'b0, 1'b0, 23'h0, 32'h0);
        drain(40);
        t = cyc;
        cmd_q.push_back('{1'b1, 23'h000600, 32'h5A5A5A5A, t + 2});
        cpl1_q.push_back('{32'hC0DE0300, t + 6});
        cmd_q.push_back('{1'b0, 23'h000500, 32'h0, t + 7});
        cpl0_q.push_back('{32'hC0DE0500, t + 11});
        pulse(1'b1, 1'b0, 23'h000500, 32'h0, 1'b1, 1'b1, 23'h000600, 32'h5A5A5A5A);
        drain(60);

        // m1 write lands on the cycle of m0's s_ready; served next, m0_spo untouched.
        t = cyc;
        cmd_q.push_back('{1'b0, 23'h000700, 32'h0, t + 2});
        cpl0_q.push_back('{32'hC0DE0700, t + 6});
        cmd_q.push_back('{1'b1, 23'h000800, 32'h11112222, t + 7});
        cpl1_q.push_back('{32'hC0DE0300, t + 11});
        pulse(1'b1, 1'b0, 23'h000700, 32'h0, 1'b0, 1'b0, 23'h0, 32'h0);
        repeat (4) @(negedge clk);
        pulse(1'b0, 1'b0, 23'h0, 32'h0, 1'b0, 1'b1, 23'h000800, 32'h11112222);
        drain(60);
        check("m0_spo_kept", 64'(m0_spo), 64'hC0DE0700);
        check("m1_spo_kept", 64'(m1_spo), 64'hC0DE0300);

        // Duplicate m0_rd while granted (WAIT and completion cycle) is ignored.
        t = cyc;
        cmd_q.push_back('{1'b0, 23'h000900, 32'h0, t + 2});
        cpl0_q.push_back('{32'hC0DE0900, t + 6});
        pulse(1'b1, 1'b0, 23'h000900, 32'h0, 1'b0, 1'b0, 23'h0, 32'h0);
        repeat (2) @(negedge clk);
        pulse(1'b1, 1'b0, 23'h000A00, 32'h0, 1'b0, 1'b0, 23'h0, 32'h0);
        @(negedge clk);
        pulse(1'b1, 1'b0, 23'h000A00, 32'h0, 1'b0, 1'b0, 23'h0, 32'h0);
        drain(40);

        // Stray s_ready while idle produces nothing.
        stray = 1'b1;
        repeat (4) @(negedge clk);
        check("stray_busy", {63'd0, busy}, 64'd0);

        // Reset during WAIT abandons the transaction; the late s_ready is ignored.
        resp_delay = 6;
        t = cyc;
        cmd_q.push_back('{1'b0, 23'h000B00, 32'h0, t + 2});
        pulse(1'b1, 1'b0, 23'h000B00, 32'h0, 1'b0, 1'b0, 23'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("wait_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        repeat (6) @(negedge clk);
        check("late_ready_busy", {63'd0, busy}, 64'd0);
        check("late_ready_m0_spo", 64'(m0_spo), 64'd0);
        resp_delay = 3;
        t = cyc;
        cmd_q.push_back('{1'b0, 23'h000100, 32'h0, t + 2});
        cpl0_q.push_back('{32'h12345678, t + 6});
        pulse(1'b1, 1'b0, 23'h000100, 32'h0, 1'b0, 1'b0, 23'h0, 32'h0);
        drain(40);

`ifdef PSRAM_ARB_TIMEOUT_EN
        // No controller answer: completion after 16 WAIT cycles with the pattern.
        resp_en = 1'b0;
        t = cyc;
        cmd_q.push_back('{1'b0, 23'h000C00, 32'h0, t + 2});
        cpl0_q.push_back('{32'hDEADBEEF, t + 19});
        pulse(1'b1, 1'b0, 23'h000C00, 32'h0, 1'b0, 1'b0, 23'h0, 32'h0);
        drain(60);
        check("tmo_err", {63'd0, err}, 64'd1);
        repeat (5) @(negedge clk);
        check("tmo_err_held", {63'd0, err}, 64'd1);
        resp_en = 1'b1;
`else
        check("err_tied_low", {63'd0, err}, 64'd0);
`endif

        check("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, want finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
